// File: rtl/ext_code_pkg.sv
// Shared types and constants for the external code store loader.
package ext_code_pkg;

    localparam int NPAGE_DEF = 8;
    localparam int IDX_W     = 8;
    localparam int CODE_W    = 32;

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_SET_INDEX = 8'hA5;
    localparam logic [7:0] OP_SET_CODE  = 8'h5A;
    localparam logic [7:0] OP_BURST     = 8'hC3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GET_IDX,
        ST_GET_CNT,
        ST_GET_CODE,
        ST_IDX_SETUP,
        ST_IDX_PULSE,
        ST_IDX_HOLD,
        ST_CODE_SETUP,
        ST_CODE_PULSE,
        ST_CODE_HOLD,
        ST_DRAIN
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_PULSE,
        PH_HOLD
    } phase_t;

    // A burst is legal when the start page exists and the count fits below it.
    function automatic logic burst_ok(input logic [7:0] s, input logic [7:0] n, input int npage);
        return (int'(s) < npage) && (n != 8'd0) && (int'(n) <= int'(s) + 1);
    endfunction

endpackage

// File: rtl/ext_code_loader_if.sv
// Host byte stream plus the store-facing strobe/data bundle.
interface ext_code_loader_if;
    import ext_code_pkg::*;

    logic [7:0]        iByte;
    logic              iByteValid;
    logic              oByteReady;
    logic              iRun;
    logic              oSET_INDEX_FLAG;
    logic [IDX_W-1:0]  oSET_INDEX;
    logic              oSET_CODE_FLAG;
    logic [CODE_W-1:0] oSET_CODE;
    logic              oBusy;
    logic              oErr;

    modport master (
        output iByte, iByteValid, iRun,
        input  oByteReady, oSET_INDEX_FLAG, oSET_INDEX, oSET_CODE_FLAG, oSET_CODE, oBusy, oErr
    );

    modport slave (
        input  iByte, iByteValid, iRun,
        output oByteReady, oSET_INDEX_FLAG, oSET_INDEX, oSET_CODE_FLAG, oSET_CODE, oBusy, oErr
    );

endinterface

// File: rtl/ext_strobe_timer.sv
// Shared setup/pulse/hold sequencer producing a registered strobe for
// either the index or the code line, with per-phase completion pulses.
module ext_strobe_timer
    import ext_code_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 4,
    parameter int HOLD_CYC  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic sel_code_i,
    output logic idx_strobe_o,
    output logic code_strobe_o,
    output logic setup_done_o,
    output logic pulse_done_o,
    output logic hold_done_o
);

    localparam int CNT_W = 16;

    phase_t             phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sel_q, sel_d;
    logic               idx_strobe_q, idx_strobe_d;
    logic               code_strobe_q, code_strobe_d;
    logic [CNT_W-1:0]   limit;
    logic               phase_last;

    // Terminal count of the phase currently running.
    always_comb begin
        case (phase_q)
            PH_SETUP: limit = CNT_W'(SETUP_CYC - 1);
            PH_PULSE: limit = CNT_W'(PULSE_CYC - 1);
            PH_HOLD:  limit = CNT_W'(HOLD_CYC - 1);
            default:  limit = '0;
        endcase
    end

    assign phase_last   = (cnt_q == limit);
    assign setup_done_o = (phase_q == PH_SETUP) && phase_last;
    assign pulse_done_o = (phase_q == PH_PULSE) && phase_last;
    assign hold_done_o  = (phase_q == PH_HOLD)  && phase_last;

    // Phase advance; a start always restarts from SETUP and latches the target line.
    always_comb begin
        // NOTE: every next-state value gets a default first so no latch is inferred.
        phase_d = phase_q;
        cnt_d   = cnt_q + 1'b1;
        sel_d   = sel_q;
        if (phase_last) begin
            cnt_d = '0;
            case (phase_q)
                PH_SETUP: phase_d = PH_PULSE;
                PH_PULSE: phase_d = PH_HOLD;
                default:  phase_d = PH_IDLE;
            endcase
        end
        if (phase_q == PH_IDLE) begin
            cnt_d = '0;
        end
        if (start_i) begin
            phase_d = PH_SETUP;
            cnt_d   = '0;
            sel_d   = sel_code_i;
        end
        idx_strobe_d  = (phase_d == PH_PULSE) && !sel_d;
        code_strobe_d = (phase_d == PH_PULSE) &&  sel_d;
    end

    // Phase registers; strobes are flopped so the store sees clean edges.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            phase_q       <= PH_IDLE;
            cnt_q         <= '0;
            sel_q         <= 1'b0;
            idx_strobe_q  <= 1'b0;
            code_strobe_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            cnt_q         <= cnt_d;
            sel_q         <= sel_d;
            idx_strobe_q  <= idx_strobe_d;
            code_strobe_q <= code_strobe_d;
        end
    end

    assign idx_strobe_o  = idx_strobe_q;
    assign code_strobe_o = code_strobe_q;

endmodule

// File: rtl/ext_code_loader.sv
// Host command decoder feeding the external code store: parses SET_INDEX,
// SET_CODE and BURST commands and sequences timed index/code strobes.
module ext_code_loader
    import ext_code_pkg::*;
#(
    parameter int NPAGE       = NPAGE_DEF,
    parameter int SETUP_CYC   = 2,
    parameter int PULSE_CYC   = 4,
    parameter int HOLD_CYC    = 2,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              iClk,
    input  logic              iRst,
    ext_code_loader_if.slave  bus
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    state_t             state_q, state_d;
    logic               burst_q, burst_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [7:0]         idx_q, idx_d;
    logic [7:0]         left_q, left_d;
    logic [9:0]         drain_q, drain_d;
    logic [23:0]        shift_q, shift_d;
    logic [IDX_W-1:0]   index_out_q, index_out_d;
    logic [CODE_W-1:0]  code_out_q, code_out_d;
    logic               err_q, err_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;

    logic in_wait, ready, accept, timeout;
    logic timer_start, timer_sel_code;
    logic idx_strobe, code_strobe, setup_done, pulse_done, hold_done;

    ext_strobe_timer #(
        .SETUP_CYC (SETUP_CYC),
        .PULSE_CYC (PULSE_CYC),
        .HOLD_CYC  (HOLD_CYC)
    ) u_timer (
        .clk           (iClk),
        .rst           (iRst),
        .start_i       (timer_start),
        .sel_code_i    (timer_sel_code),
        .idx_strobe_o  (idx_strobe),
        .code_strobe_o (code_strobe),
        .setup_done_o  (setup_done),
        .pulse_done_o  (pulse_done),
        .hold_done_o   (hold_done)
    );

    assign in_wait = (state_q == ST_GET_IDX) || (state_q == ST_GET_CNT) ||
                     (state_q == ST_GET_CODE) || (state_q == ST_DRAIN);
    assign ready   = ((state_q == ST_IDLE) && !bus.iRun) || in_wait;
    assign accept  = ready && bus.iByteValid;

    // Command decode, burst bookkeeping and inter-byte timeout.
    always_comb begin
        state_d        = state_q;
        burst_d        = burst_q;
        byte_cnt_d     = byte_cnt_q;
        idx_d          = idx_q;
        left_d         = left_q;
        drain_d        = drain_q;
        shift_d        = shift_q;
        index_out_d    = index_out_q;
        code_out_d     = code_out_q;
        err_d          = err_q;
        to_cnt_d       = '0;
        timeout        = 1'b0;
        timer_start    = 1'b0;
        timer_sel_code = 1'b0;

        if (in_wait && !accept) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                timeout = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (bus.iByte)
                        OP_NOP:       err_d = 1'b0;
                        OP_SET_INDEX: begin burst_d = 1'b0; state_d = ST_GET_IDX; end
                        OP_SET_CODE:  begin burst_d = 1'b0; byte_cnt_d = '0; state_d = ST_GET_CODE; end
                        OP_BURST:     begin burst_d = 1'b1; state_d = ST_GET_IDX; end
                        default:      err_d = 1'b1;
                    endcase
                end
            end
            ST_GET_IDX: begin
                if (accept) begin
                    if (burst_q) begin
                        idx_d   = bus.iByte;
                        state_d = ST_GET_CNT;
                    end else if (int'(bus.iByte) < NPAGE) begin
                        index_out_d = bus.iByte;
                        timer_start = 1'b1;
                        state_d     = ST_IDX_SETUP;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GET_CNT: begin
                if (accept) begin
                    if (burst_ok(idx_q, bus.iByte, NPAGE)) begin
                        left_d     = bus.iByte;
                        byte_cnt_d = '0;
                        state_d    = ST_GET_CODE;
                    end else begin
                        // Swallow the payload the host will still send, keeping framing.
                        err_d   = 1'b1;
                        drain_d = {bus.iByte, 2'b00};
                        state_d = (bus.iByte == 8'd0) ? ST_IDLE : ST_DRAIN;
                    end
                end
            end
            ST_GET_CODE: begin
                if (accept) begin
                    if (byte_cnt_q == 2'd3) begin
                        code_out_d  = {shift_q, bus.iByte};
                        timer_start = 1'b1;
                        if (burst_q) begin
                            index_out_d = idx_q;
                            state_d     = ST_IDX_SETUP;
                        end else begin
                            timer_sel_code = 1'b1;
                            state_d        = ST_CODE_SETUP;
                        end
                    end else begin
                        shift_d    = {shift_q[15:0], bus.iByte};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            ST_IDX_SETUP:  if (setup_done) state_d = ST_IDX_PULSE;
            ST_IDX_PULSE:  if (pulse_done) state_d = ST_IDX_HOLD;
            ST_IDX_HOLD: begin
                if (hold_done) begin
                    if (burst_q) begin
                        timer_start    = 1'b1;
                        timer_sel_code = 1'b1;
                        state_d        = ST_CODE_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_CODE_SETUP: if (setup_done) state_d = ST_CODE_PULSE;
            ST_CODE_PULSE: if (pulse_done) state_d = ST_CODE_HOLD;
            ST_CODE_HOLD: begin
                if (hold_done) begin
                    if (burst_q && (left_q > 8'd1)) begin
                        left_d     = left_q - 8'd1;
                        idx_d      = idx_q - 8'd1;
                        byte_cnt_d = '0;
                        state_d    = ST_GET_CODE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (accept) begin
                    drain_d = drain_q - 10'd1;
                    if (drain_q == 10'd1) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (timeout) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
        end
    end

    // Loader state and output data registers.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q     <= ST_IDLE;
            burst_q     <= 1'b0;
            byte_cnt_q  <= '0;
            idx_q       <= '0;
            left_q      <= '0;
            drain_q     <= '0;
            shift_q     <= '0;
            index_out_q <= '0;
            code_out_q  <= '0;
            err_q       <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            byte_cnt_q  <= byte_cnt_d;
            idx_q       <= idx_d;
            left_q      <= left_d;
            drain_q     <= drain_d;
            shift_q     <= shift_d;
            index_out_q <= index_out_d;
            code_out_q  <= code_out_d;
            err_q       <= err_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign bus.oByteReady      = ready;
    assign bus.oBusy           = (state_q != ST_IDLE);
    assign bus.oErr            = err_q;
    assign bus.oSET_INDEX      = index_out_q;
    assign bus.oSET_CODE       = code_out_q;
    assign bus.oSET_INDEX_FLAG = idx_strobe;
    assign bus.oSET_CODE_FLAG  = code_strobe;

endmodule

// File: tb/tb_ext_code_loader.sv
// Self-checking bench for ext_code_loader: directed and randomized command
// streams compared against a transaction-level model of the store writes.
module tb_ext_code_loader;
    import ext_code_pkg::*;

    localparam int TO = 64;

    typedef struct packed {
        logic        is_code;
        logic [31:0] val;
    } ev_t;
    typedef logic [7:0] bytes_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ext_code_loader_if bus();

    ext_code_loader #(
        .NPAGE       (8),
        .SETUP_CYC   (2),
        .PULSE_CYC   (4),
        .HOLD_CYC    (2),
        .TIMEOUT_CYC (TO)
    ) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    int  n_checks = 0;
    int  n_pass   = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];
    bit  m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Strobe monitor: records every rising strobe with its data, and counts
    // timing-rule breaches (width, setup, hold, overlap, ready during strobe).
    logic       p_if, p_cf;
    logic [7:0] p_idx;
    logic [31:0] p_code;
    int idx_age, code_age, fall_age, width;
    int width_viol = 0, setup_viol = 0, hold_viol = 0, overlap_viol = 0;

    always @(negedge clk) begin
        if (rst) begin
            p_if = 0; p_cf = 0; p_idx = 0; p_code = 0;
            idx_age = 100; code_age = 100; fall_age = 100; width = 0;
        end else begin
            fall_age++;
            idx_age  = (bus.oSET_INDEX != p_idx)  ? 0 : idx_age + 1;
            code_age = (bus.oSET_CODE  != p_code) ? 0 : code_age + 1;
            if (((bus.oSET_INDEX != p_idx) || (bus.oSET_CODE != p_code)) &&
                (fall_age < 2 || p_if || p_cf || bus.oSET_INDEX_FLAG || bus.oSET_CODE_FLAG))
                hold_viol++;
            if (bus.oSET_INDEX_FLAG && !p_if) begin
                obs_q.push_back({1'b0, 24'h0, bus.oSET_INDEX});
                if (idx_age < 2) setup_viol++;
            end
            if (bus.oSET_CODE_FLAG && !p_cf) begin
                obs_q.push_back({1'b1, bus.oSET_CODE});
                if (code_age < 2) setup_viol++;
            end
            if (bus.oSET_INDEX_FLAG || bus.oSET_CODE_FLAG) width++;
            if ((p_if && !bus.oSET_INDEX_FLAG) || (p_cf && !bus.oSET_CODE_FLAG)) begin
                if (width != 4) width_viol++;
                width    = 0;
                fall_age = 0;
            end
            if ((bus.oSET_INDEX_FLAG && bus.oSET_CODE_FLAG) ||
                (bus.oByteReady && (bus.oSET_INDEX_FLAG || bus.oSET_CODE_FLAG)))
                overlap_viol++;
            p_if   = bus.oSET_INDEX_FLAG;
            p_cf   = bus.oSET_CODE_FLAG;
            p_idx  = bus.oSET_INDEX;
            p_code = bus.oSET_CODE;
        end
    end

    // Reference model: the store writes each complete command should produce.
    task automatic model_cmd(input bytes_t c);
        int s, n;
        case (c[0])
            OP_NOP:       m_err = 0;
            OP_SET_INDEX: if (c[1] < 8) exp_q.push_back({1'b0, 24'h0, c[1]}); else m_err = 1;
            OP_SET_CODE:  exp_q.push_back({1'b1, c[1], c[2], c[3], c[4]});
            OP_BURST: begin
                s = int'(c[1]);
                n = int'(c[2]);
                if (s < 8 && n >= 1 && n <= s + 1) begin
                    for (int k = 0; k < n; k++) begin
                        exp_q.push_back({1'b0, 24'h0, 8'(s - k)});
                        exp_q.push_back({1'b1, c[3+4*k], c[4+4*k], c[5+4*k], c[6+4*k]});
                    end
                end else begin
                    m_err = 1;
                end
            end
            default: m_err = 1;
        endcase
    endtask

    // Offers one byte; returns at #1 after the edge that accepted it.
    task automatic send_byte(input logic [7:0] b);
        bit got = 0;
        bus.iByte      = b;
        bus.iByteValid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.oByteReady) begin got = 1; break; end
        end
        @(posedge clk);
        #1;
        bus.iByteValid = 1'b0;
        if (!got) check("byte_accept_timeout", 32'(got), 32'd1);
    endtask

    task automatic send_cmd(input bytes_t c, input bit gaps);
        foreach (c[i]) begin
            send_byte(c[i]);
            if (gaps) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
        model_cmd(c);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!bus.oBusy) break;
        end
        check({tag, "_idle"}, 32'(bus.oBusy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_events(input string tag);
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check({tag, "_kind"}, 32'(obs_q[i].is_code), 32'(exp_q[i].is_code));
            check({tag, "_val"},  obs_q[i].val, exp_q[i].val);
        end
        obs_q.delete();
        exp_q.delete();
        check({tag, "_err"}, 32'(bus.oErr), 32'(m_err));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bytes_t c;
        logic [11:0] fl, bz, rd;
        logic [7:0]  ix;
        logic        b63, b64;
        int          s, n;

        bus.iByte = 8'h00; bus.iByteValid = 1'b0; bus.iRun = 1'b0;
        m_err = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_idx_flag",  32'(bus.oSET_INDEX_FLAG), 32'd0);
        check("rst_code_flag", 32'(bus.oSET_CODE_FLAG),  32'd0);
        check("rst_index",     32'(bus.oSET_INDEX),      32'd0);
        check("rst_code",      bus.oSET_CODE,            32'd0);
        check("rst_busy",      32'(bus.oBusy),           32'd0);
        check("rst_err",       32'(bus.oErr),            32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("idle_ready", 32'(bus.oByteReady), 32'd1);

        // SET_INDEX 3: exact cycle timing after the index byte
        send_byte(8'hA5);
        send_byte(8'h03);
        ix = bus.oSET_INDEX;
        for (int i = 0; i < 12; i++) begin
            fl[i] = bus.oSET_INDEX_FLAG;
            bz[i] = bus.oBusy;
            rd[i] = bus.oByteReady;
            @(posedge clk); #1;
        end
        c = {8'hA5, 8'h03};
        model_cmd(c);
        check("si_data_t1",   32'(ix), 32'd3);
        check("si_flag_shape", 32'(fl), 32'h03C);
        check("si_busy_shape", 32'(bz), 32'h0FF);
        check("si_ready_shape", 32'(rd), 32'hF00);
        check_events("si3");

        // SET_CODE with iRun raised mid-command
        send_byte(8'h5A);
        bus.iRun = 1'b1;
        c = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        foreach (c[i]) send_byte(c[i]);
        c = {8'h5A, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        model_cmd(c);
        wait_idle("sc");
        check("sc_code",  bus.oSET_CODE, 32'hDEADBEEF);
        check("sc_index_kept", 32'(bus.oSET_INDEX), 32'd3);
        check_events("sc");

        // iRun high in IDLE blocks opcodes
        check("run_ready", 32'(bus.oByteReady), 32'd0);
        bus.iByte = 8'h77; bus.iByteValid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("run_blocked_err",  32'(bus.oErr),  32'd0);
        check("run_blocked_busy", 32'(bus.oBusy), 32'd0);
        bus.iByteValid = 1'b0;
        bus.iRun = 1'b0;

        // Full burst over all eight pages
        c = {8'hC3, 8'h07, 8'h08};
        for (int i = 0; i < 32; i++) c.push_back(8'($urandom));
        send_cmd(c, 1'b1);
        wait_idle("b8");
        check_events("b8");

        // Random legal bursts
        for (int r = 0; r < 3; r++) begin
            s = $urandom_range(0, 7);
            n = $urandom_range(1, s + 1);
            c = {OP_BURST, 8'(s), 8'(n)};
            for (int i = 0; i < 4 * n; i++) c.push_back(8'($urandom));
            send_cmd(c, 1'b1);
            wait_idle("brnd");
            check_events("brnd");
        end

        // Smallest legal burst
        c = {8'hC3, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
        send_cmd(c, 1'b0);
        wait_idle("b01");
        check_events("b01");

        // Illegal count: drains exactly 20 bytes, then normal command works
        c = {8'hC3, 8'h02, 8'h05};
        for (int i = 0; i < 20; i++) c.push_back(8'hA5);
        send_cmd(c, 1'b0);
        check("drain_done_busy", 32'(bus.oBusy), 32'd0);
        check_events("drain");
        c = {8'hA5, 8'h01};
        send_cmd(c, 1'b0);
        wait_idle("after_drain");
        check_events("after_drain");
        c = {8'h00};
        send_cmd(c, 1'b0);
        check_events("nop_clear");

        // Illegal start page drains 4 bytes
        c = {8'hC3, 8'h08, 8'h01, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
        send_cmd(c, 1'b0);
        check("drain_s_busy", 32'(bus.oBusy), 32'd0);
        check_events("bad_s");

        // Zero count drains nothing
        c = {8'h00};
        send_cmd(c, 1'b0);
        c = {8'hC3, 8'h05, 8'h00};
        send_cmd(c, 1'b0);
        check("n0_busy", 32'(bus.oBusy), 32'd0);
        check_events("n0");

        // Invalid index and unknown opcode
        c = {8'h00};
        send_cmd(c, 1'b0);
        c = {8'hA5, 8'h09};
        send_cmd(c, 1'b0);
        check("badidx_busy", 32'(bus.oBusy), 32'd0);
        check_events("badidx");
        c = {8'h00};
        send_cmd(c, 1'b0);
        check_events("nop2");
        c = {8'h77};
        send_cmd(c, 1'b0);
        check("badop_busy", 32'(bus.oBusy), 32'd0);
        check_events("badop");
        c = {8'h00};
        send_cmd(c, 1'b0);

        // Inter-byte timeout in the middle of SET_CODE
        send_byte(8'h5A);
        send_byte(8'h11);
        send_byte(8'h22);
        for (int i = 0; i < TO + 4; i++) begin
            if (i == TO - 1) b63 = bus.oBusy;
            if (i == TO)     b64 = bus.oBusy;
            @(posedge clk); #1;
        end
        m_err = 1;
        check("to_busy_last_stall", 32'(b63), 32'd1);
        check("to_busy_after",      32'(b64), 32'd0);
        check_events("timeout");

        // Reset in the middle of an index strobe
        c = {8'hA5, 8'h05};
        send_cmd(c, 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.oSET_INDEX_FLAG) break;
        end
        #2 rst = 1'b1;
        #1;
        check("rst_mid_flag",  32'(bus.oSET_INDEX_FLAG), 32'd0);
        check("rst_mid_index", 32'(bus.oSET_INDEX),      32'd0);
        m_err = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_busy", 32'(bus.oBusy), 32'd0);
        check_events("rst_mid");

        // Strobe timing rules over the whole run
        check("width_viol",   32'(width_viol),   32'd0);
        check("setup_viol",   32'(setup_viol),   32'd0);
        check("hold_viol",    32'(hold_viol),    32'd0);
        check("overlap_viol", 32'(overlap_viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
